// File: rtl/i2c_target_regfile_pkg.sv
// Shared definitions for the I2C target register file: FSM encoding and bus bit levels.
package i2c_target_regfile_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  function automatic logic is_ack_state(input state_t s);
    return (s == ST_ADDR_ACK) || (s == ST_PTR_ACK) ||
           (s == ST_WDATA_ACK) || (s == ST_RDATA_ACK);
  endfunction

endpackage

// File: rtl/i2c_target_regfile_sync_edge.sv
// Multi-flop synchroniser for an asynchronous bus pin, followed by one flop for edge detection.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  // Idle I2C lines sit high, so resetting to 1 avoids a spurious edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '1;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign q    = sync_reg[SYNC_STAGES-1];
  assign rise = q & ~prev_reg;
  assign fall = ~q & prev_reg;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with 7-bit address match, pointer auto-increment and a byte register file.
module i2c_target_regfile
  import i2c_target_regfile_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl,
  inout  wire                   sda,
  output logic                  wr_strobe,
  output logic [PW-1:0]         wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic [NUM_REGS*8-1:0] regs_flat
);

  logic scl_q, scl_rise, scl_fall;
  logic sda_q, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst_n(rst_n), .d_in(scl), .q(scl_q), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst_n(rst_n), .d_in(sda), .q(sda_q), .rise(sda_rise), .fall(sda_fall)
  );

  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic [PW-1:0] ptr_reg;
  logic          rw_reg;
  logic          sda_drive_reg, sda_drive_next;
  logic          busy_reg, busy_next;
  logic          wr_strobe_reg;
  logic [PW-1:0] wr_addr_reg;
  logic [7:0]    wr_data_reg;
  logic [7:0]    regs_mem [NUM_REGS];

  logic       start_ev, stop_ev, last_bit, ninth_done, load_read;
  logic [7:0] byte_in, rd_byte;

  assign start_ev   = sda_fall & scl_q;
  assign stop_ev    = sda_rise & scl_q;
  assign last_bit   = (bit_cnt_reg == 3'd7);
  // In the ACK states the counter only marks whether the 9th SCL rise has happened.
  assign ninth_done = (bit_cnt_reg == 3'd1);
  assign byte_in    = {shift_reg[6:0], sda_q};
  assign rd_byte    = regs_mem[ptr_reg];
  assign load_read  = (state_reg == ST_RDATA_ACK) || (state_reg == ST_ADDR_ACK && rw_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (start_ev) begin
      state_next = ST_ADDR;
    end else if (stop_ev) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_ADDR:
          if (scl_rise && last_bit)
            state_next = (byte_in[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK:
          if (scl_fall && ninth_done) state_next = rw_reg ? ST_RDATA : ST_PTR;
        ST_PTR:
          if (scl_rise && last_bit) state_next = ST_PTR_ACK;
        ST_PTR_ACK, ST_WDATA_ACK:
          if (scl_fall && ninth_done) state_next = ST_WDATA;
        ST_WDATA:
          if (scl_rise && last_bit) state_next = ST_WDATA_ACK;
        ST_RDATA:
          if (scl_rise && last_bit) state_next = ST_RDATA_ACK;
        ST_RDATA_ACK:
          if (scl_rise && sda_q == I2C_NACK) state_next = ST_WAIT_STOP;
          else if (scl_fall && ninth_done)   state_next = ST_RDATA;
        default: state_next = state_reg;
      endcase
    end
  end

  // SDA drive only ever changes on a detected SCL fall (or is dropped by START/STOP).
  always_comb begin
    sda_drive_next = sda_drive_reg;
    busy_next      = busy_reg;
    if (start_ev) begin
      sda_drive_next = 1'b0;
    end else if (stop_ev) begin
      sda_drive_next = 1'b0;
      busy_next      = 1'b0;
    end else if (is_ack_state(state_reg)) begin
      if (scl_fall && !ninth_done)
        sda_drive_next = (state_reg != ST_RDATA_ACK) ? ~I2C_ACK : 1'b0;
      else if (scl_fall && ninth_done)
        sda_drive_next = load_read ? ~rd_byte[7] : 1'b0;
      if (state_reg == ST_RDATA_ACK && scl_rise && sda_q == I2C_NACK)
        busy_next = 1'b0;
    end else begin
      case (state_reg)
        ST_ADDR:
          if (scl_rise && last_bit) busy_next = (byte_in[7:1] == DEV_ADDR);
        ST_RDATA:
          if (scl_fall) sda_drive_next = ~shift_reg[6];
        ST_WAIT_STOP, ST_IDLE:
          sda_drive_next = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_drive_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      sda_drive_reg <= sda_drive_next;
      busy_reg      <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      ptr_reg       <= '0;
      rw_reg        <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_mem[i] <= '0;
    end else begin
      wr_strobe_reg <= 1'b0;
      if (start_ev || stop_ev) begin
        bit_cnt_reg <= '0;
      end else begin
        case (state_reg)
          ST_ADDR, ST_PTR, ST_WDATA:
            if (scl_rise) begin
              shift_reg   <= byte_in;
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (last_bit && state_reg == ST_ADDR) rw_reg <= sda_q;
              if (last_bit && state_reg == ST_PTR) ptr_reg <= byte_in[PW-1:0];
              if (last_bit && state_reg == ST_WDATA) begin
                regs_mem[ptr_reg] <= byte_in;
                wr_strobe_reg     <= 1'b1;
                wr_addr_reg       <= ptr_reg;
                wr_data_reg       <= byte_in;
                ptr_reg           <= ptr_reg + 1'b1;
              end
            end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK, ST_RDATA_ACK:
            if (scl_rise) begin
              bit_cnt_reg <= 3'd1;
              if (state_reg == ST_RDATA_ACK) ptr_reg <= ptr_reg + 1'b1;
            end else if (scl_fall && ninth_done) begin
              bit_cnt_reg <= '0;
              shift_reg   <= rd_byte;
            end
          ST_RDATA:
            if (scl_rise)      bit_cnt_reg <= bit_cnt_reg + 3'd1;
            else if (scl_fall) shift_reg   <= {shift_reg[6:0], 1'b0};
          default: ;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign regs_flat[gi*8 +: 8] = regs_mem[gi];
  end

  assign sda       = sda_drive_reg ? 1'b0 : 1'bz;
  assign busy      = busy_reg;
  assign wr_strobe = wr_strobe_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;

endmodule
